// File: rtl/qspi_pkg.sv
// Shared encodings for the QSPI slave transceiver: lane modes, FSM states and
// the mode-to-lane-count mapping used at frame start.
package qspi_pkg;

  localparam logic [1:0] MODE_1LANE  = 2'b00;
  localparam logic [1:0] MODE_2LANE  = 2'b01;
  localparam logic [1:0] MODE_4LANE  = 2'b10;
  localparam logic [1:0] MODE_1LANE_ALT = 2'b11;

  localparam logic [1:0] ST_WAIT_REL = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;

  // Requested width clamped to the lanes actually built.
  function automatic logic [2:0] lanes_from_mode(input logic [1:0] mode, input int max_lanes);
    logic [2:0] l;
    case (mode)
      MODE_2LANE: l = 3'd2;
      MODE_4LANE: l = 3'd4;
      default:    l = 3'd1;
    endcase
    if (int'(l) > max_lanes) l = 3'(max_lanes);
    return l;
  endfunction

endpackage

// File: rtl/qspi_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle
// rise/fall strobes derived from the synchronised level.
module qspi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/qspi_slave_xcvr.sv
// SPI/QSPI slave transceiver: oversampled pins, runtime 1/2/4-lane framing,
// word-level rx strobe and tx reload handshake towards user logic.
module qspi_slave_xcvr
  import qspi_pkg::*;
#(
  parameter int MAX_LANES   = 4,
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 qck,
  input  logic                 qss,
  input  logic [MAX_LANES-1:0] qd_in,
  output logic [MAX_LANES-1:0] qd_out,
  output logic [MAX_LANES-1:0] qd_oe,
  input  logic [1:0]           lane_mode,
  input  logic                 dir_tx,
  output logic [WORD_W-1:0]    rx_data,
  output logic                 rx_valid,
  input  logic [WORD_W-1:0]    tx_data,
  output logic                 tx_ready,
  output logic                 frame_act,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(WORD_W);
  typedef logic [CNT_W:0] cnt_ext_t;

  logic                 qck_q, qck_rise, qck_fall;
  logic                 qss_q, qss_rise, qss_fall;
  logic [MAX_LANES-1:0] qd_q, qd_rise, qd_fall;
  logic [2*MAX_LANES:0] sync_unused;

  qspi_sync #(.STAGES(SYNC_STAGES)) u_qck (
    .clk(clk), .reset(reset), .d(qck), .q(qck_q), .rise(qck_rise), .fall(qck_fall)
  );
  qspi_sync #(.STAGES(SYNC_STAGES)) u_qss (
    .clk(clk), .reset(reset), .d(qss), .q(qss_q), .rise(qss_rise), .fall(qss_fall)
  );
  for (genvar i = 0; i < MAX_LANES; i++) begin : g_qd
    qspi_sync #(.STAGES(SYNC_STAGES)) u_qd (
      .clk(clk), .reset(reset), .d(qd_in[i]), .q(qd_q[i]), .rise(qd_rise[i]), .fall(qd_fall[i])
    );
  end
  assign sync_unused = {qck_q, qd_rise, qd_fall};

  logic [1:0]           state;
  logic [2:0]           lanes;
  logic                 dir;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_W-1:0]    rx_shift;
  logic [WORD_W-1:0]    tx_shift;
  logic                 word_done;
  logic                 rx_done;

  logic                 one_lane, rx_en, tx_en;
  logic [MAX_LANES-1:0] lane_mask;
  logic [WORD_W-1:0]    beat_in, rx_next, tx_top;
  cnt_ext_t             cnt_sum;
  logic                 cnt_wrap;
  logic [CNT_W-1:0]     cnt_next;

  assign one_lane  = (lanes == 3'd1);
  assign rx_en     = one_lane | ~dir;
  assign tx_en     = one_lane | dir;
  assign lane_mask = MAX_LANES'((5'd1 << lanes) - 5'd1);
  assign beat_in   = WORD_W'(qd_q & lane_mask);
  assign rx_next   = (rx_shift << lanes) | beat_in;
  assign cnt_sum   = cnt_ext_t'(cnt) + cnt_ext_t'(lanes);
  assign cnt_wrap  = (cnt_sum == cnt_ext_t'(WORD_W));
  assign cnt_next  = cnt_wrap ? '0 : cnt_sum[CNT_W-1:0];
  // Current beat sits at the bottom of tx_top; lane L-1 carries its MSB.
  assign tx_top    = tx_shift >> cnt_ext_t'(WORD_W - int'(lanes));

  always_comb begin
    qd_out = '0;
    qd_oe  = '0;
    if (frame_act) begin
      if (one_lane) begin
        qd_out = MAX_LANES'({tx_top[0], 1'b0});
        qd_oe  = MAX_LANES'(2'b10);
      end else if (dir) begin
        qd_out = tx_top[MAX_LANES-1:0] & lane_mask;
        qd_oe  = lane_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_WAIT_REL;
      lanes     <= 3'd1;
      dir       <= 1'b0;
      cnt       <= '0;
      word_done <= 1'b0;
      rx_done   <= 1'b0;
      frame_act <= 1'b0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
      // Completed word is published one cycle after its final beat lands.
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
      case (state)
        ST_WAIT_REL: if (qss_q) state <= ST_IDLE;
        ST_IDLE: begin
          if (qss_fall) begin
            state     <= ST_ACTIVE;
            lanes     <= lanes_from_mode(lane_mode, MAX_LANES);
            dir       <= dir_tx;
            cnt       <= '0;
            word_done <= 1'b0;
            tx_shift  <= tx_data;
            tx_ready  <= 1'b1;
            frame_act <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (qck_rise) begin
            rx_shift <= rx_next;
            cnt      <= cnt_next;
            if (cnt_wrap) begin
              word_done <= 1'b1;
              rx_done   <= rx_en;
            end
          end else if (qck_fall) begin
            if (word_done) begin
              word_done <= 1'b0;
              if (tx_en) begin
                tx_shift <= tx_data;
                tx_ready <= 1'b1;
              end
            end else begin
              tx_shift <= tx_shift << lanes;
            end
          end
          // A beat landing in the same cycle as release still counts.
          if (qss_rise) begin
            state     <= ST_IDLE;
            frame_act <= 1'b0;
            frame_err <= ((qck_rise ? cnt_next : cnt) != '0);
          end
        end
        default: state <= ST_WAIT_REL;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_slave_xcvr.sv
// Bench for qspi_slave_xcvr: a bus master drives frames, expected words and
// pin beats go into queues, and independent monitors pop and compare.
module tb_qspi_slave_xcvr;

  localparam int W    = 8;
  localparam int ML   = 4;
  localparam int SS   = 2;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          qck = 1'b0;
  logic          qss_m = 1'b1;
  logic          sel2 = 1'b0;
  logic [ML-1:0] qd_in = '0;
  logic [1:0]    lane_mode = 2'b00;
  logic          dir_tx = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic          qss1, qss2;

  logic [ML-1:0] qd_out1, qd_oe1;
  logic [W-1:0]  rx_data1;
  logic          rx_valid1, tx_ready1, frame_act1, frame_err1;
  logic [1:0]    qd_out2, qd_oe2;
  logic [W-1:0]  rx_data2;
  logic          rx_valid2, tx_ready2, frame_act2, frame_err2;

  assign qss1 = sel2 ? 1'b1 : qss_m;
  assign qss2 = sel2 ? qss_m : 1'b1;

  qspi_slave_xcvr #(.MAX_LANES(ML), .WORD_W(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .qck(qck), .qss(qss1), .qd_in(qd_in),
    .qd_out(qd_out1), .qd_oe(qd_oe1), .lane_mode(lane_mode), .dir_tx(dir_tx),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data), .tx_ready(tx_ready1),
    .frame_act(frame_act1), .frame_err(frame_err1)
  );

  qspi_slave_xcvr #(.MAX_LANES(2), .WORD_W(W), .SYNC_STAGES(SS)) dut2 (
    .clk(clk), .reset(reset), .qck(qck), .qss(qss2), .qd_in(qd_in[1:0]),
    .qd_out(qd_out2), .qd_oe(qd_oe2), .lane_mode(lane_mode), .dir_tx(dir_tx),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data), .tx_ready(tx_ready2),
    .frame_act(frame_act2), .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ML-1:0] oe;
    logic [ML-1:0] out;
  } beat_t;

  beat_t        exp_beat[$];
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] exp_rx2[$];
  int           n_rxv[2];
  int           n_txr[2];
  int           n_err[2];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] rxw[8];
  logic [W-1:0] txw[8];
  int           ti = 0;
  logic         fa_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lanes_of(input logic [1:0] m, input int maxl);
    int l;
    l = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    return (l > maxl) ? maxl : l;
  endfunction

  // Clock-cycle wait that also plays the user side of the tx handshake.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if ((sel2 ? tx_ready2 : tx_ready1) && ti < 7) begin
        ti++;
        tx_data = txw[ti];
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      rxw[i] = W'($urandom);
      txw[i] = W'($urandom);
    end
  endtask

  task automatic qck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      qd_in = ML'($urandom);
      cyc(HALF); qck = 1'b1;
      cyc(HALF); qck = 1'b0;
    end
  endtask

  task automatic frame(input logic [1:0] m, input bit d, input int nbeats, input int maxl);
    int            L, bpw, s, r0, t0, e0;
    bit            rxen, txen;
    logic [W-1:0]  keep, t;
    logic [ML-1:0] msk, v;
    beat_t         e;
    s    = sel2 ? 1 : 0;
    L    = lanes_of(m, maxl);
    bpw  = W / L;
    rxen = (L == 1) || !d;
    txen = (L == 1) || d;
    msk  = ML'((1 << L) - 1);
    r0 = n_rxv[s]; t0 = n_txr[s]; e0 = n_err[s];
    keep = s ? rx_data2 : rx_data1;
    lane_mode = m; dir_tx = d;
    ti = 0; tx_data = txw[0];
    cyc(2);
    qss_m = 1'b0;
    cyc(HALF + 3);
    chk("frame_act_on", s ? frame_act2 : frame_act1, 1);
    for (int b = 0; b < nbeats; b++) begin
      v = ML'($urandom);
      v = (v & ~msk) | (ML'(rxw[b / bpw] >> (W - L * (b % bpw + 1))) & msk);
      qd_in = v;
      cyc(HALF);
      if (s == 0) begin
        t = txw[b / bpw] >> (W - L * (b % bpw + 1));
        e.oe = '0; e.out = '0;
        if (L == 1) begin
          e.oe = ML'(2); e.out = ML'({t[0], 1'b0});
        end else if (d) begin
          e.oe = msk; e.out = ML'(t) & msk;
        end
        exp_beat.push_back(e);
      end
      if (rxen && (b % bpw) == bpw - 1) begin
        if (s == 0) exp_rx.push_back(rxw[b / bpw]);
        else exp_rx2.push_back(rxw[b / bpw]);
      end
      qck = 1'b1;
      cyc(HALF);
      qck = 1'b0;
    end
    cyc(HALF + 3);
    qss_m = 1'b1;
    cyc(8);
    chk("rx_valid_count", n_rxv[s] - r0, rxen ? nbeats / bpw : 0);
    chk("tx_ready_count", n_txr[s] - t0, 1 + (txen ? nbeats / bpw : 0));
    chk("frame_err_count", n_err[s] - e0, (nbeats % bpw) != 0);
    if (nbeats < bpw) chk("rx_data_held", s ? rx_data2 : rx_data1, keep);
    chk("frame_act_off", s ? frame_act2 : frame_act1, 0);
    if (s == 0) chk("qd_oe_idle", qd_oe1, 0);
    chk("rx_queue_drained", exp_rx.size() + exp_rx2.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rx_valid1) begin
      n_rxv[0]++;
      if (exp_rx.size() == 0) chk("rx_unexpected", rx_data1, 32'hFFFF_FFFF);
      else chk("rx_data", rx_data1, exp_rx.pop_front());
    end
    if (rx_valid2) begin
      n_rxv[1]++;
      if (exp_rx2.size() == 0) chk("rx2_unexpected", rx_data2, 32'hFFFF_FFFF);
      else chk("rx2_data", rx_data2, exp_rx2.pop_front());
    end
    if (tx_ready1) n_txr[0]++;
    if (tx_ready2) n_txr[1]++;
    if (frame_err1) n_err[0]++;
    if (frame_err2) n_err[1]++;
    if (fa_prev && !frame_act1) chk("qd_oe_on_release", qd_oe1, 0);
    fa_prev = frame_act1;
  end

  always @(posedge qck) begin
    if (!sel2 && exp_beat.size() != 0) begin
      beat_t b;
      b = exp_beat.pop_front();
      chk("qd_oe_beat", qd_oe1, b.oe);
      chk("qd_out_beat", qd_out1, b.out);
    end
  end

  initial begin
    int r0, t0;
    fill_random();
    repeat (4) @(negedge clk);
    chk("rst_rx_data", rx_data1, 0);
    chk("rst_rx_valid", rx_valid1, 0);
    chk("rst_tx_ready", tx_ready1, 0);
    chk("rst_frame_act", frame_act1, 0);
    chk("rst_frame_err", frame_err1, 0);
    chk("rst_qd_oe", qd_oe1, 0);
    chk("rst_qd_out", qd_out1, 0);
    reset = 1'b0;
    cyc(8);

    fill_random();
    rxw[0] = 8'hA5; rxw[1] = 8'h3C; txw[0] = 8'h81; txw[1] = 8'h7E;
    frame(2'b00, 1'b0, 16, ML);

    fill_random(); rxw[0] = 8'hD2;
    frame(2'b10, 1'b0, 2, ML);

    fill_random(); txw[0] = 8'h5F;
    frame(2'b10, 1'b1, 2, ML);

    fill_random();
    frame(2'b01, 1'b0, 3, ML);

    fill_random(); rxw[0] = 8'h96;
    sel2 = 1'b1;
    frame(2'b10, 1'b0, 4, 2);
    sel2 = 1'b0;
    cyc(4);

    lane_mode = 2'b00; dir_tx = 1'b0;
    qss_m = 1'b0;
    cyc(8);
    qck_pulses(3);
    reset = 1'b1; cyc(2); reset = 1'b0;
    r0 = n_rxv[0]; t0 = n_txr[0];
    qck_pulses(5);
    cyc(8);
    chk("rst_mid_rx_valid", n_rxv[0] - r0, 0);
    chk("rst_mid_tx_ready", n_txr[0] - t0, 0);
    chk("rst_mid_frame_act", frame_act1, 0);
    chk("rst_mid_rx_data", rx_data1, 0);
    qss_m = 1'b1;
    cyc(8);
    fill_random(); rxw[0] = 8'h42;
    frame(2'b00, 1'b0, 8, ML);

    for (int n = 0; n < 10; n++) begin
      logic [1:0] m;
      bit         d;
      int         bpw;
      fill_random();
      m   = 2'($urandom);
      d   = 1'($urandom);
      bpw = W / lanes_of(m, ML);
      frame(m, d, 1 + int'($urandom_range(0, 3 * bpw - 1)), ML);
    end

    chk("beat_queue_drained", exp_beat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
